// File: rtl/random_range_sampler.sv
// rtl/random_range_sampler.sv - unbiased index in [0, N) from raw random words via mask-and-reject
module random_range_sampler #(
    parameter int WIDTH      = 32,
    parameter int IDX_W      = 16,
    parameter int MAX_REJECT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] rnd_in,
    input  logic             rnd_valid,
    output logic             rnd_ready,
    input  logic             req_valid,
    input  logic [IDX_W-1:0] req_n,
    output logic             req_ready,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic [IDX_W-1:0] idx_out,
    output logic             idx_fallback,
    output logic             idx_err,
    output logic [15:0]      reject_total
);

    localparam int REJ_W = $clog2(MAX_REJECT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_DRAW,
        ST_OUT
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] n_q;
    logic [IDX_W-1:0] mask_q;
    logic [IDX_W-1:0] mask_next;
    logic [IDX_W-1:0] cand;
    logic [REJ_W-1:0] rej_cnt;

    // Only the low IDX_W bits of each random word take part in sampling.
    generate
        if (WIDTH > IDX_W) begin : g_unused_hi
            logic unused_rnd_hi;
            assign unused_rnd_hi = ^rnd_in[WIDTH-1:IDX_W];
        end
    endgenerate

    // Smallest all-ones mask covering N-1: smear the top set bit of N-1 downwards.
    always_comb begin
        mask_next = n_q - IDX_W'(1);
        for (int i = 0; i < IDX_W; i++) begin
            mask_next = mask_next | (mask_next >> 1);
        end
    end

    assign cand = rnd_in[IDX_W-1:0] & mask_q;

    // Request/draw/result state machine; every output is a register so reset clears them all.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            n_q          <= '0;
            mask_q       <= '0;
            rej_cnt      <= '0;
            req_ready    <= 1'b0;
            rnd_ready    <= 1'b0;
            idx_valid    <= 1'b0;
            idx_out      <= '0;
            idx_fallback <= 1'b0;
            idx_err      <= 1'b0;
            reject_total <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        n_q       <= req_n;
                        rej_cnt   <= '0;
                        req_ready <= 1'b0;
                        if (req_n == '0) begin
                            // Empty range: report the error without touching the word stream.
                            idx_out   <= '0;
                            idx_err   <= 1'b1;
                            idx_valid <= 1'b1;
                            state     <= ST_OUT;
                        end else begin
                            state <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    mask_q    <= mask_next;
                    rnd_ready <= 1'b1;
                    state     <= ST_DRAW;
                end
                ST_DRAW: begin
                    if (rnd_valid) begin
                        if (cand < n_q) begin
                            idx_out      <= cand;
                            idx_fallback <= 1'b0;
                            idx_valid    <= 1'b1;
                            rnd_ready    <= 1'b0;
                            state        <= ST_OUT;
                        end else begin
                            if (reject_total != 16'hFFFF) begin
                                reject_total <= reject_total + 16'd1;
                            end
                            if (rej_cnt == REJ_W'(MAX_REJECT - 1)) begin
                                // cand <= mask <= 2N-1, so cand-N always lands in range.
                                idx_out      <= cand - n_q;
                                idx_fallback <= 1'b1;
                                idx_valid    <= 1'b1;
                                rnd_ready    <= 1'b0;
                                state        <= ST_OUT;
                            end else begin
                                rej_cnt <= rej_cnt + REJ_W'(1);
                            end
                        end
                    end
                end
                ST_OUT: begin
                    if (idx_ready) begin
                        idx_valid    <= 1'b0;
                        idx_fallback <= 1'b0;
                        idx_err      <= 1'b0;
                        req_ready    <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/random_range_sampler.md
Name: random_range_sampler

Overview:
- Consumer side of the pseudorandom word stream.
- Takes raw WIDTH-bit random words from the shift-register generator and returns an unbiased index in [0, N) on request.
- Uses mask-and-reject sampling, with a bounded fallback so latency never grows without limit.
- Used by the solver to pick a random clause or variable; one request outstanding at a time.

Parameters:
- WIDTH, 32, width of incoming random word.
- IDX_W, 16, width of range bound and output index; IDX_W <= WIDTH.
- MAX_REJECT, 8, consecutive rejections before the fallback result is used; must be >= 1.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- rnd_in  in  WIDTH  random word; only bits [IDX_W-1:0] are used
- rnd_valid  in  1  rnd_in valid; tie high when the generator free-runs
- rnd_ready  out  1  sampler consumes rnd_in this cycle when rnd_valid && rnd_ready
- req_valid  in  1  request for a new index
- req_n  in  IDX_W  range bound N, sampled when the request is accepted
- req_ready  out  1  high only in IDLE
- idx_valid  out  1  result valid
- idx_ready  in  1  downstream accepts result
- idx_out  out  IDX_W  sampled index
- idx_fallback  out  1  result came from the fallback path
- idx_err  out  1  request had N == 0
- reject_total  out  16  saturating count of rejected words since reset

Behaviour:
- Reset values: all outputs 0, state IDLE, internal registers cleared. Reset in any state aborts the request in flight; no result is produced for it.
- IDLE:
  - req_ready=1.
  - On req_valid: latch N=req_n, clear rej_cnt.
  - If N==0, set idx_out=0, idx_err=1, go to OUT; no random words are consumed.
  - Otherwise go to SETUP.
- SETUP (1 cycle):
  - Register mask = smallest (2^k - 1) >= N-1; N=1 gives mask=0.
  - Go to DRAW.
- DRAW:
  - rnd_ready=1.
  - Each cycle with rnd_valid: cand = rnd_in[IDX_W-1:0] & mask.
    - cand < N: idx_out=cand, idx_fallback=0, go to OUT.
    - Otherwise: increment reject_total (saturates at 0xFFFF). If rej_cnt == MAX_REJECT-1, set idx_out=cand-N, idx_fallback=1, go to OUT; else increment rej_cnt and stay.
  - Fallback is always in range: cand <= mask <= 2N-1.
  - rnd_valid low: hold state, no consumption.
- OUT:
  - idx_valid=1, rnd_ready=0, req_ready=0.
  - idx_out, idx_fallback and idx_err are held stable until idx_valid && idx_ready.
  - On handshake: clear idx_valid, idx_fallback and idx_err, go to IDLE. idx_out keeps its last value.
- Latency:
  - Request accepted at edge t: SETUP in cycle t+1, first draw in t+2.
  - With rnd_valid=1 and first word accepted, idx_valid=1 in cycle t+3.
  - Each rejection adds 1 cycle. Worst case with rnd_valid=1: t+2+MAX_REJECT.
- A new request is accepted no earlier than the cycle after the idx handshake (req_ready is 0 outside IDLE).
- rnd_ready is never asserted outside DRAW. No word is consumed without being evaluated.
- All comparisons are unsigned. cand-N is computed in IDX_W bits.

Test Plan:
- Basic accept: N=10, rnd_valid=1, rnd_in=0x00000007 -> mask 0xF, idx_out=7 at t+3, fallback=0, exactly 1 word consumed, reject_total=0.
- Rejections: N=10, word sequence 0x0C, 0x0F, 0x13 -> first two rejected, third gives cand=3, idx_out=3, 3 words consumed, reject_total=2.
- Fallback: MAX_REJECT=8, N=10, eight words of 0x0E -> idx_out=4, idx_fallback=1, idx_valid at t+10, reject_total=8.
- Edge ranges:
  - N=0 -> idx_err=1, idx_out=0, rnd_ready never asserted.
  - N=1 with any word (e.g. 0xFFFFFFFF) -> idx_out=0.
  - N=0x8000 with word 0x0001FFFF -> mask 0x7FFF, idx_out=0x7FFF.
- Backpressure:
  - idx_ready low for 5 cycles in OUT -> idx_out stable, rnd_ready=0, req_ready=0.
  - rnd_valid low 3 cycles in DRAW -> no state change.
  - A req_valid held high during OUT is accepted only after the handshake.
- Reset mid-operation: assert reset in DRAW after one rejection -> next cycle state IDLE, all outputs 0, reject_total=0; a fresh N=10 request with word 0x05 -> idx_out=5.
